// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetch queue between a pipelined req/gnt/rvalid imem and the core fetch stage.
// Define IFQ_BYPASS_EN to forward a response straight onto InstrF when the queue is empty.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  input  logic        StallF,
  output logic [31:0] InstrF,
  output logic        FetchStall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C   = DEPTH[CW:0];
  localparam logic [CW:0] MAX_OUT_C = MAX_OUT[CW:0];

  logic [31:0]   queue [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [31:0]   sp;
  logic [31:0]   nf_pc;

  logic          redirect;
  logic          q_hit;
  logic          resp_ok;
  logic          bypass;
  logic          hit;
  logic          consume;
  logic          pop;
  logic          push;
  logic          grant;
  logic [CW:0]   reserved;
  logic [CW:0]   outstanding;

  assign redirect = (PCF != sp);
  assign q_hit    = (count != '0) && !redirect;
  // A response is usable only when no stale responses are still owed to a flushed stream.
  assign resp_ok  = imem_rvalid && !redirect && (drop_cnt == '0) && (inflight != '0);

`ifdef IFQ_BYPASS_EN
  assign bypass = resp_ok && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign hit        = q_hit || bypass;
  assign consume    = hit && !StallF;
  assign pop        = consume && q_hit;
  assign push       = resp_ok && !(bypass && !StallF);
  assign FetchStall = !hit;
  assign InstrF     = q_hit ? queue[rd_ptr] : (bypass ? imem_rdata : 32'h0);

  // Queue slots are reserved at issue; stale (dropped) requests still occupy memory-side credits.
  assign reserved    = {1'b0, count} + {1'b0, inflight};
  assign outstanding = {1'b0, inflight} + {1'b0, drop_cnt};
  assign imem_req    = !reset && !redirect && (reserved < DEPTH_C) && (outstanding < MAX_OUT_C);
  assign imem_addr   = nf_pc;
  assign grant       = imem_req && imem_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop_cnt <= '0;
      sp       <= RESET_PC;
      nf_pc    <= RESET_PC;
    end else if (redirect) begin
      rd_ptr   <= wr_ptr;
      count    <= '0;
      sp       <= PCF;
      nf_pc    <= PCF;
      inflight <= '0;
      // Everything still owed by memory belongs to the old stream; a response landing now is one of them.
      drop_cnt <= drop_cnt + inflight - CW'(imem_rvalid && ((drop_cnt != '0) || (inflight != '0)));
    end else begin
      if (grant)   nf_pc  <= nf_pc + 32'd4;
      if (consume) sp     <= sp + 32'd4;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      count    <= count + CW'(push) - CW'(pop);
      inflight <= inflight + CW'(grant) - CW'(resp_ok);
      if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= imem_rdata;
  end

`ifndef SYNTHESIS
  a_pc_aligned: assert property (@(posedge clk) disable iff (reset) PCF[1:0] == 2'b00);
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> ((inflight != '0) || (drop_cnt != '0)));
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: pipelined imem model with latency/backpressure and a PC-trace scoreboard.
module tb_ifetch_queue;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
`ifdef IFQ_BYPASS_EN
  localparam int FIRST_HIT = 1;
`else
  localparam int FIRST_HIT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF;
  logic        StallF;
  logic [31:0] InstrF;
  logic        FetchStall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .StallF(StallF), .InstrF(InstrF),
    .FetchStall(FetchStall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ready; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  pend_t pend[$];
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    lat = 1;
  int    gnt_pct = 100;
  logic  stall_ext = 1'b0;
  logic  s_stall, s_req;
  logic [31:0] s_instr, s_addr;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One core/memory cycle: drive at negedge, sample, then commit memory and PC updates after posedge.
  task automatic cycle();
    logic consumed;
    exp_t e;
    @(negedge clk);
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_fn(pend[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    StallF = stall_ext;
    #1;
    StallF = stall_ext | FetchStall;
    #1;
    s_stall = FetchStall; s_instr = InstrF; s_req = imem_req; s_addr = imem_addr;
    if (FetchStall) check_eq("nop_on_stall", InstrF, 32'h0);
    check_eq("max_outstanding", {31'b0, (pend.size() <= MAX_OUT)}, 32'd1);
    consumed = !FetchStall && !StallF;
    if (consumed) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", PCF, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("pc_trace", PCF, e.pc);
        check_eq("instr", InstrF, e.instr);
        $display("[%0d] pc=%08h instr=%08h", cyc, PCF, InstrF);
      end
    end
    @(posedge clk);
    if (imem_rvalid) void'(pend.pop_front());
    if (s_req && imem_gnt) pend.push_back('{s_addr, cyc + lat});
    cyc++;
    #1;
    if (consumed) begin
      PCF = PCF + 32'd4;
      sb.push_back('{PCF, mem_fn(PCF)});
    end
  endtask

  task automatic jump(input logic [31:0] target, input logic chk);
    PCF = target;
    sb.delete();
    sb.push_back('{target, mem_fn(target)});
    cycle();
    if (chk) check_eq("redirect_req_low", {31'b0, s_req}, 32'h0);
  endtask

  task automatic run_until_pc(input logic [31:0] target, input int budget);
    for (int i = 0; i < budget && PCF != target; i++) cycle();
    check_eq("reach_pc", PCF, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; PCF = 32'h0; StallF = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("rst_stall", {31'b0, FetchStall}, 32'h1);
    check_eq("rst_instr", InstrF, 32'h0);
    reset = 1'b0;
    sb.push_back('{32'h0, mem_fn(32'h0)});

    // Minimum-latency startup: sequential requests, first hit after FIRST_HIT cycles.
    for (int c = 0; c < 3; c++) begin
      cycle();
      check_eq("lat_req", {31'b0, s_req}, 32'h1);
      check_eq("lat_addr", s_addr, 32'(4 * c));
      if (c < FIRST_HIT) check_eq("lat_stall", {31'b0, s_stall}, 32'h1);
      else if (c == FIRST_HIT) begin
        check_eq("lat_stall", {31'b0, s_stall}, 32'h0);
        check_eq("lat_instr", s_instr, mem_fn(32'h0));
      end
    end
    repeat (5) cycle();

    // Core stall fills the queue; requests must stop, then the stream resumes in order.
    stall_ext = 1'b1;
    repeat (6) cycle();
    check_eq("full_req_low", {31'b0, s_req}, 32'h0);
    stall_ext = 1'b0;
    run_until_pc(PCF + 32'h20, 40);

    // Redirect 0x10 -> 0x400 with two requests in flight.
    lat = 3;
    jump(32'h0, 1'b1);
    run_until_pc(32'h10, 60);
    stall_ext = 1'b1;
    for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
    check_eq("two_inflight", 32'(pend.size()), 32'd2);
    stall_ext = 1'b0;
    jump(32'h400, 1'b1);
    run_until_pc(32'h410, 60);

    // Back-to-back redirects before any response returns.
    jump(32'h400, 1'b1);
    jump(32'h800, 1'b1);
    jump(32'h40, 1'b1);
    run_until_pc(32'h60, 80);

    // Latency 3 with random grant backpressure, core stalls and occasional jumps.
    gnt_pct = 60;
    for (int i = 0; i < 400; i++) begin
      stall_ext = ($urandom_range(4) == 0);
      if (i % 97 == 50) jump({18'b0, 12'($urandom), 2'b00}, 1'b0);
      else cycle();
    end
    stall_ext = 1'b0;
    gnt_pct = 100;
    jump(32'h100, 1'b1);
    run_until_pc(32'h120, 80);

    // Reset mid-flight: outputs go to reset values at once, a stray response during reset is ignored.
    stall_ext = 1'b1;
    repeat (3) cycle();
    check_eq("midflight_outstanding", {31'b0, (pend.size() != 0)}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("async_rst_stall", {31'b0, FetchStall}, 32'h1);
    check_eq("async_rst_instr", InstrF, 32'h0);
    PCF = 32'h0;
    pend.delete();
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    reset = 1'b0;
    stall_ext = 1'b0;
    lat = 1;
    sb.delete();
    sb.push_back('{32'h0, mem_fn(32'h0)});
    cycle();
    check_eq("restart_addr", s_addr, 32'h0);
    check_eq("restart_req", {31'b0, s_req}, 32'h1);
    run_until_pc(32'h20, 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
